jt51_noise_ctrl: RTL and testbench

Sequencer for the JT51 noise LFSR. It turns the programmed noise frequency (NFRQ, 5 bits) and noise enable (NE) into single-cycle `base` shift strobes paced by the sample-period `zero` strobe, and captures the LFSR output bit for the operator datapath. It sits between the register file and the noise LFSR, which it drives through `base` and reads through `lfsr_out`.

---
 rtl/jt51_noise_ctrl.sv | 145 ++++++++++++++
 tb/tb_jt51_noise_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_noise_ctrl.sv
// jt51_noise_ctrl
// Paces the noise LFSR: turns the programmed noise frequency and enable
// into one-cycle `base` shift strobes counted in `zero` sample periods,
// and captures the LFSR output bit for the operator datapath.
// Register writes land in a shadow copy. The sequencer consumes that copy
// from IDLE at once; while running, it consumes it at a period boundary,
// except for a disable, which it honours immediately.

module jt51_noise_ctrl #(
  parameter int NFRQ_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              cfg_wr,
  input  logic              cfg_ne,
  input  logic [NFRQ_W-1:0] cfg_nfrq,
  input  logic              zero,
  input  logic              lfsr_out,
  output logic              base,
  output logic              noise_en,
  output logic              noise_sample
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Sequencer state
  state_t            r_state;
  logic [NFRQ_W-1:0] r_act_nfrq;
  logic [NFRQ_W-1:0] r_cnt;

  // Shadow of the last register write, waiting to be consumed
  logic              r_sh_ne;
  logic [NFRQ_W-1:0] r_sh_nfrq;
  logic              r_pend;

  // Registered outputs
  logic              r_base;
  logic              r_noise_en;
  logic              r_noise_sample;

  // Next-state values
  state_t            w_state_nx;
  logic [NFRQ_W-1:0] w_act_nx;
  logic [NFRQ_W-1:0] w_cnt_nx;
  logic              w_consume;
  logic              w_fire;

  // Next-state logic. The reload value (2^NFRQ_W - 1) - nfrq is simply ~nfrq.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_state_nx = r_state;
    w_act_nx   = r_act_nfrq;
    w_cnt_nx   = r_cnt;
    w_consume  = 1'b0;
    w_fire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend) begin
          w_consume = 1'b1;
          if (r_sh_ne) begin
            w_act_nx   = r_sh_nfrq;
            w_state_nx = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (zero) begin
          w_cnt_nx   = ~r_act_nfrq;
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_pend && !r_sh_ne) begin
          // A disable wins over a zero in the same cycle, so no base is issued.
          w_consume  = 1'b1;
          w_state_nx = ST_IDLE;
        end else if (zero) begin
          if (r_cnt == '0) begin
            w_fire = 1'b1;
            // A pending frequency change lands only at the period boundary.
            if (r_pend) begin
              w_consume = 1'b1;
              w_act_nx  = r_sh_nfrq;
            end
            w_cnt_nx = ~w_act_nx;
          end else begin
            w_cnt_nx = r_cnt - NFRQ_W'(1);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Shadow capture runs on every clk edge; consumption needs clk_en.
  // A new write beats a consumption in the same cycle, so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_ne   <= 1'b0;
      r_sh_nfrq <= '0;
      r_pend    <= 1'b0;
    end else if (cfg_wr) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register updates from the values it had before the clock edge.
      r_sh_ne   <= cfg_ne;
      r_sh_nfrq <= cfg_nfrq;
      r_pend    <= 1'b1;
    end else if (clk_en && w_consume) begin
      r_pend <= 1'b0;
    end
  end

  // Sequencer registers and outputs, all frozen while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_act_nfrq     <= '0;
      r_cnt          <= '0;
      r_base         <= 1'b0;
      r_noise_en     <= 1'b0;
      r_noise_sample <= 1'b0;
    end else if (clk_en) begin
      r_state    <= w_state_nx;
      r_act_nfrq <= w_act_nx;
      r_cnt      <= w_cnt_nx;
      r_base     <= w_fire;
      r_noise_en <= (w_state_nx != ST_IDLE);
      // Take the LFSR bit as it stands before the shift this base causes.
      if (r_base) begin
        r_noise_sample <= lfsr_out;
      end
    end
  end

  assign base         = r_base;
  assign noise_en     = r_noise_en;
  assign noise_sample = r_noise_sample;

endmodule

// File: tb/tb_jt51_noise_ctrl.sv
// Testbench for jt51_noise_ctrl: directed scenarios plus randomized traffic,
// each compared cycle by cycle against a reference model that counts zero
// strobes down to the next base.

module tb_jt51_noise_ctrl;

  localparam int NFRQ_W = 5;
  localparam int STEPS  = 1 << NFRQ_W;   // zero strobes per period at NFRQ=0

  logic              clk;
  logic              rst_n;
  logic              clk_en;
  logic              cfg_wr;
  logic              cfg_ne;
  logic [NFRQ_W-1:0] cfg_nfrq;
  logic              zero;
  logic              lfsr_out;
  logic              base;
  logic              noise_en;
  logic              noise_sample;

  jt51_noise_ctrl #(.NFRQ_W(NFRQ_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .cfg_wr       (cfg_wr),
    .cfg_ne       (cfg_ne),
    .cfg_nfrq     (cfg_nfrq),
    .zero         (zero),
    .lfsr_out     (lfsr_out),
    .base         (base),
    .noise_en     (noise_en),
    .noise_sample (noise_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_base = 0;   // cycles in which the DUT showed base high

  // Reference model.
  // m_running: the noise generator is enabled (ARM or RUN).
  // m_armed: the first zero has been seen since enabling.
  // m_left: zero strobes still needed before the next base; the strobe
  // that brings it to zero issues the base.
  bit m_running, m_armed;
  int m_left, m_act;
  bit m_sh_ne, m_pend;
  int m_sh_nfrq;
  bit m_base, m_nen, m_sample;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_armed = 0; m_left = 0; m_act = 0;
    m_sh_ne = 0; m_sh_nfrq = 0; m_pend = 0;
    m_base = 0; m_nen = 0; m_sample = 0;
  endtask

  // One rising clock edge, applied to the model using the inputs present at that edge.
  task automatic model_edge();
    bit fire;
    bit consume;
    fire = 0;
    consume = 0;
    if (clk_en) begin
      if (m_base) m_sample = lfsr_out;
      if (!m_running) begin
        if (m_pend) begin
          consume = 1;
          if (m_sh_ne) begin
            m_running = 1;
            m_armed   = 0;
            m_act     = m_sh_nfrq;
          end
        end
      end else if (!m_armed) begin
        if (zero) begin
          m_armed = 1;
          m_left  = STEPS - m_act;
        end
      end else if (m_pend && !m_sh_ne) begin
        consume   = 1;
        m_running = 0;
        m_armed   = 0;
      end else if (zero) begin
        m_left--;
        if (m_left == 0) begin
          fire = 1;
          if (m_pend) begin
            consume = 1;
            m_act   = m_sh_nfrq;
          end
          m_left = STEPS - m_act;
        end
      end
      m_base = fire;
      m_nen  = m_running;
      if (consume) m_pend = 0;
    end
    if (cfg_wr) begin
      m_sh_ne   = cfg_ne;
      m_sh_nfrq = int'(cfg_nfrq);
      m_pend    = 1;
    end
  endtask

  // Advance one clock with the inputs already set, then compare #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("base", base, m_base);
    check("noise_en", noise_en, m_nen);
    check("noise_sample", noise_sample, m_sample);
    if (base === 1'b1) n_base++;
    lfsr_out = 1'($urandom);
  endtask

  task automatic idle(input int n);
    cfg_wr = 0; zero = 0; clk_en = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_zero();
    cfg_wr = 0; zero = 1; clk_en = 1;
    step();
    zero = 0;
  endtask

  // n zero strobes, one every `gap` cycles
  task automatic run_zeros(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      idle(gap - 1);
      do_zero();
    end
  endtask

  task automatic write(input bit ne, input int nfrq);
    cfg_wr = 1; cfg_ne = ne; cfg_nfrq = NFRQ_W'(nfrq); zero = 0; clk_en = 1;
    step();
    cfg_wr = 0;
  endtask

  // Assert reset between clock edges and check the outputs clear before any edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("rst_base", base, 0);
    check("rst_noise_en", noise_en, 0);
    check("rst_noise_sample", noise_sample, 0);
    model_reset();
    cfg_wr = 0; zero = 0; clk_en = 1;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; clk_en = 1; cfg_wr = 0; cfg_ne = 0; cfg_nfrq = '0;
    zero = 0; lfsr_out = 0;
    model_reset();
    #3;
    check("por_base", base, 0);
    check("por_noise_en", noise_en, 0);
    check("por_noise_sample", noise_sample, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Without any write, zero strobes never produce a base.
    n_base = 0;
    run_zeros(100, 2);
    check("no_write_no_base", n_base, 0);

    // Fastest rate: first base after the 2nd zero, then one per zero.
    write(1, 31);
    n_base = 0;
    run_zeros(1, 32);
    check("fast_noise_en", noise_en, 1);
    check("fast_first_zero_arms", n_base, 0);
    run_zeros(1, 32);
    check("fast_first_base", n_base, 1);
    run_zeros(8, 32);
    check("fast_base_count", n_base, 9);

    // A mid-run reset aborts the generator at once.
    async_reset();
    idle(2);

    // Slowest rate: one base every 32 zeros.
    write(1, 0);
    n_base = 0;
    run_zeros(32, 4);
    check("slow_before_first", n_base, 0);
    run_zeros(1, 4);
    check("slow_first_base", n_base, 1);
    run_zeros(31, 4);
    check("slow_before_second", n_base, 1);
    run_zeros(1, 4);
    check("slow_second_base", n_base, 2);
    idle(2);

    // Mid-run change from period 4 to period 2, written two zeros after a base.
    async_reset();
    write(1, 28);
    n_base = 0;
    run_zeros(11, 3);
    check("period4_bases", n_base, 2);
    write(1, 30);
    run_zeros(7, 3);
    check("period_change_bases", n_base, 5);

    // Disable, with the write visible to an expiring zero.
    async_reset();
    write(1, 31);
    run_zeros(3, 3);
    idle(1);
    write(0, 31);
    n_base = 0;
    do_zero();
    check("disable_no_base", n_base, 0);
    check("disable_noise_en", noise_en, 0);
    idle(3);
    check("disable_quiet", n_base, 0);
    write(1, 31);
    run_zeros(1, 3);
    check("reenable_noise_en", noise_en, 1);
    check("reenable_arm_only", n_base, 0);
    run_zeros(1, 3);
    check("reenable_first_base", n_base, 1);

    // clk_en gating: a gated zero is ignored, base holds while gated, and a
    // write made while gated takes effect later.
    idle(2);
    n_base = 0;
    clk_en = 0; zero = 1;
    step();
    step();
    clk_en = 1; zero = 0;
    step();
    check("gated_zero_ignored", n_base, 0);
    do_zero();
    clk_en = 0; cfg_wr = 1; cfg_ne = 1; cfg_nfrq = NFRQ_W'(30);
    step();
    cfg_wr = 0;
    step();
    step();
    check("gated_base_hold", base, 1);
    clk_en = 1;
    step();
    check("base_drops_after_resume", base, 0);
    n_base = 0;
    run_zeros(4, 3);
    check("gated_write_applied", n_base, 2);

    // Randomized traffic
    async_reset();
    for (int i = 0; i < 4000; i++) begin
      clk_en = ($urandom_range(0, 7) != 0);
      zero   = ($urandom_range(0, 3) == 0);
      cfg_wr = ($urandom_range(0, 39) == 0);
      cfg_ne = ($urandom_range(0, 3) != 0);
      cfg_nfrq = ($urandom_range(0, 1) == 1) ? NFRQ_W'($urandom_range(24, 31))
                                             : NFRQ_W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
